wb_rr_arbiter: RTL
==================

Name: wb_rr_arbiter

Overview:
- Parameterised Wishbone B3 round-robin arbiter that shares one slave, such as the on-chip RAM slave, between NM masters.
- Sits between the masters and one slave port, replacing the fixed 3-master select logic.
- Grant is held for the whole CYC of the winning master, so bursts are never split.
- Provides fair rotation, a grant status vector and an optional bus watchdog.

Parameters:
- NM, 4, number of masters (2..8)
- dw, 32, data width
- aw, 15, address width
- TIMEOUT, 255, watchdog limit in cycles (used only with the macro)
- TW, 8, watchdog counter width; must satisfy TIMEOUT < 2**TW

Ports:
- wb_clk_i  in  1  clock, rising edge
- wb_rst_i  in  1  reset, synchronous, active-low
- m_cyc_i  in  NM  per-master CYC
- m_stb_i  in  NM  per-master STB
- m_we_i  in  NM  per-master WE
- m_adr_i  in  NM*aw  master i at bits [i*aw +: aw]
- m_dat_i  in  NM*dw  master write data, same packing
- m_sel_i  in  NM*4  byte selects
- m_cti_i  in  NM*3  cycle type
- m_bte_i  in  NM*2  burst type
- m_ack_o  out  NM  ACK returned to master i
- m_err_o  out  NM  ERR returned to master i
- m_rty_o  out  NM  RTY returned to master i
- m_dat_o  out  dw  read data, broadcast to all masters
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_adr_o  out  aw  to slave
- s_dat_o  out  dw  to slave
- s_sel_o  out  4  to slave
- s_cti_o  out  3  to slave
- s_bte_o  out  2  to slave
- s_ack_i, s_err_i, s_rty_i  in  1 each  from slave
- s_dat_i  in  dw  from slave
- gnt_o  out  NM  one-hot current grant (registered)
- arb_timeout_o  out  1  watchdog pulse

Behaviour:
- Reset (wb_rst_i=0 at a clock edge):
  - gnt <= 0; last <= NM-1, so master 0 has top priority afterwards.
  - Watchdog counter <= 0.
  - Consequently all m_ack_o/m_err_o/m_rty_o = 0, all s_* outputs = 0, arb_timeout_o = 0.
  - Reset asserted mid-transfer drops the grant at that edge; no ACK is forwarded afterwards.
- State machine, two states derived from gnt:
  - IDLE (gnt==0):
    - If any m_cyc_i is high, the winner is the first requester found scanning (last+1) mod NM upward with wrap-around.
    - At the next edge: gnt <= onehot(winner), last <= winner.
    - Arbitration latency is 1 cycle from CYC assertion to s_cyc_o.
  - GRANT (gnt[g]==1):
    - Held while m_cyc_i[g]=1, regardless of other requests and of CTI/BTE.
    - When m_cyc_i[g]=0 is sampled, gnt <= 0.
    - There is exactly one dead cycle (IDLE) between consecutive grants, including re-grant to the same master.
- Fairness:
  - Requests from all NM masters held continuously produce grants in order g, g+1, …, wrapping.
  - No master waits more than NM-1 other tenures.
- Simultaneous events:
  - A new CYC arriving in the same cycle the owner drops CYC is not considered until IDLE.
  - Multiple new requests in IDLE are resolved by the rotating pointer only.
- Datapath mux (combinational from registered gnt):
  - s_* = granted master's fields; s_cyc_o = m_cyc_i[g] & gnt[g].
  - All s_* = 0 when gnt==0.
  - m_ack_o[i] = s_ack_i & gnt[i]; m_err_o and m_rty_o are gated the same way.
  - m_dat_o = s_dat_i unconditionally.
- gnt_o = gnt.

Optional Feature:
- Macro: WB_ARB_WATCHDOG_EN.
- With the macro, the TW-bit counter:
  - Clears when gnt==0, when s_stb_o==0, or when any of s_ack_i/s_err_i/s_rty_i is high.
  - Otherwise increments.
- When the counter == TIMEOUT, for that one cycle:
  - m_err_o[g]=1.
  - s_cyc_o and s_stb_o are forced to 0.
  - arb_timeout_o=1.
  - The counter clears at the next edge.
  - The master owns recovery; the grant persists until it drops CYC.
- Without the macro: no counter logic, arb_timeout_o tied 0, ERR is purely the slave's.

Test Plan:
- Reset, all CYC low -> gnt_o=0, s_cyc_o=0, all m_ack_o=0. Release reset, m_cyc_i=4'b0001 at cycle 0 -> gnt_o=0001 at cycle 1, s_adr_o=m_adr_i[0].
- m_cyc_i=4'b1111 held, each owner drops CYC after 3 cycles then re-raises -> grant order 0,1,2,3,0 with one gnt_o=0 cycle between tenures.
- Master 2 performs an 8-beat incrementing burst (cti=3'b010, last beat 3'b111) while master 0 requests -> gnt_o stays 0100 for all 8 ACKs; master 0 is granted 2 cycles after master 2 drops CYC.
- Slave ACKs while gnt=0010 -> m_ack_o=0010 only; m_ack_o[0]/[2]/[3] stay 0 even when s_ack_i=1 with gnt=0.
- Reset pulled low mid-burst (master 1, beat 4) -> gnt_o=0 at that edge; after release master 0 wins over a simultaneous master 1 request.
- WB_ARB_WATCHDOG_EN, TIMEOUT=16, slave never ACKs -> m_err_o[g] and arb_timeout_o pulse for exactly 1 cycle, 16 cycles after s_stb_o rises; without the macro, ERR never asserts.

Source files
------------

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for wb_rr_arbiter: NM packed Wishbone B3 master ports plus one
// shared slave port. The arbiter uses the slave modport (it is the slave seen
// by the masters); whatever drives the masters and models the shared slave
// uses the master modport.
interface wb_rr_arbiter_if #(
  parameter int unsigned NM = 4,
  parameter int unsigned dw = 32,
  parameter int unsigned aw = 15
);
  // master side, field i packed at [i*width +: width]
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [NM-1:0]    m_we_i;
  logic [NM*aw-1:0] m_adr_i;
  logic [NM*dw-1:0] m_dat_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [NM*3-1:0]  m_cti_i;
  logic [NM*2-1:0]  m_bte_i;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [NM-1:0]    m_rty_o;
  logic [dw-1:0]    m_dat_o;

  // shared slave side
  logic             s_cyc_o;
  logic             s_stb_o;
  logic             s_we_o;
  logic [aw-1:0]    s_adr_o;
  logic [dw-1:0]    s_dat_o;
  logic [3:0]       s_sel_o;
  logic [2:0]       s_cti_o;
  logic [1:0]       s_bte_o;
  logic             s_ack_i;
  logic             s_err_i;
  logic             s_rty_i;
  logic [dw-1:0]    s_dat_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i,
    output m_ack_o, m_err_o, m_rty_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o,
    input  s_ack_i, s_err_i, s_rty_i, s_dat_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i,
    input  m_ack_o, m_err_o, m_rty_o, m_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o,
    output s_ack_i, s_err_i, s_rty_i, s_dat_i
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Wishbone B3 round-robin arbiter sharing one slave between NM masters.
// The grant is held for the whole CYC of the winner; one idle cycle separates
// tenures. Optional bus watchdog enabled by defining WB_ARB_WATCHDOG_EN.
module wb_rr_arbiter #(
  parameter int unsigned NM      = 4,
  parameter int unsigned dw      = 32,
  parameter int unsigned aw      = 15,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_rr_arbiter_if.slave  bus,
  output logic [NM-1:0]   gnt_o,
  output logic            arb_timeout_o
);

  localparam int unsigned LW = (NM > 1) ? $clog2(NM) : 1;

  // Reject unsupported configurations at elaboration
  if (NM < 2 || NM > 8) begin : g_bad_nm
    $error("wb_rr_arbiter: NM must be 2..8");
  end
  if (TW < 32 && TIMEOUT >= (32'd1 << TW)) begin : g_bad_tw
    $error("wb_rr_arbiter: TIMEOUT must fit in TW bits");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e         state_c;
  logic [NM-1:0]  gnt_q, gnt_d;
  logic [LW-1:0]  last_q, last_d;
  logic           found_c;
  int unsigned    idx_c;
  logic           owner_cyc_c;
  logic           owner_stb_c;
  logic           wdt_hit_c;

  // State is implied by the grant vector
  always_comb state_c = (|gnt_q) ? ST_GRANT : ST_IDLE;

  assign owner_cyc_c = |(bus.m_cyc_i & gnt_q);
  assign owner_stb_c = |(bus.m_stb_i & gnt_q);

  // Next grant: rotating-priority pick in idle, hold until owner drops CYC
  always_comb begin
    gnt_d   = gnt_q;
    last_d  = last_q;
    found_c = 1'b0;
    idx_c   = 0;
    unique case (state_c)
      ST_IDLE: begin
        for (int unsigned k = 1; k <= NM; k++) begin
          idx_c = (32'(last_q) + k) % NM;
          if (!found_c && bus.m_cyc_i[LW'(idx_c)]) begin
            found_c = 1'b1;
            gnt_d   = NM'(1) << LW'(idx_c);
            last_d  = LW'(idx_c);
          end
        end
      end
      ST_GRANT: begin
        if (!owner_cyc_c) gnt_d = '0;
      end
    endcase
  end

  // Grant and rotation pointer; master 0 has top priority after reset
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      gnt_q  <= '0;
      last_q <= LW'(NM - 1);
    end else begin
      gnt_q  <= gnt_d;
      last_q <= last_d;
    end
  end

  // Forward the granted master's request fields; all zero with no grant
  always_comb begin
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_cti_o = '0;
    bus.s_bte_o = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (gnt_q[i]) begin
        bus.s_we_o  = bus.m_we_i[i];
        bus.s_adr_o = bus.m_adr_i[i*aw +: aw];
        bus.s_dat_o = bus.m_dat_i[i*dw +: dw];
        bus.s_sel_o = bus.m_sel_i[i*4 +: 4];
        bus.s_cti_o = bus.m_cti_i[i*3 +: 3];
        bus.s_bte_o = bus.m_bte_i[i*2 +: 2];
      end
    end
  end

  // Handshake: a watchdog hit withdraws the cycle and errors the owner
  assign bus.s_cyc_o = owner_cyc_c & ~wdt_hit_c;
  assign bus.s_stb_o = owner_stb_c & ~wdt_hit_c;
  assign bus.m_ack_o = {NM{bus.s_ack_i}} & gnt_q;
  assign bus.m_err_o = ({NM{bus.s_err_i}} | {NM{wdt_hit_c}}) & gnt_q;
  assign bus.m_rty_o = {NM{bus.s_rty_i}} & gnt_q;
  assign bus.m_dat_o = bus.s_dat_i;

  assign gnt_o         = gnt_q;
  assign arb_timeout_o = wdt_hit_c;

`ifdef WB_ARB_WATCHDOG_EN
  logic [TW-1:0] wdt_q, wdt_d;

  // Count strobed cycles with no slave termination
  always_comb begin
    wdt_d = wdt_q + TW'(1);
    if (!(|gnt_q) || !owner_stb_c || wdt_hit_c ||
        bus.s_ack_i || bus.s_err_i || bus.s_rty_i) begin
      wdt_d = '0;
    end
  end

  // Watchdog counter register
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) wdt_q <= '0;
    else           wdt_q <= wdt_d;
  end

  assign wdt_hit_c = (wdt_q == TW'(TIMEOUT));
`else
  assign wdt_hit_c = 1'b0;
`endif

endmodule
